// File: rtl/score_bcd_sequencer.sv
// score_bcd_sequencer
//   Converts a binary game score to four packed BCD digits using a
//   one-bit-per-cycle shift-add-3 (double-dabble) sequence. The result goes
//   into a holding register that feeds the 7-segment driver. That register
//   changes only when a conversion completes.
// Ports:
//   CLK100MHZ  system clock
//   reset      asynchronous, active-high
//   update     level-sampled request; each high cycle asks for a conversion
//   bin_score  unsigned binary score (saturates at MAX_SCORE)
//   bcd        {thousands, hundreds, tens, ones}
//   overflow   last loaded value was saturated
//   busy       FSM is not idle (registered)
//   done       one-cycle pulse when bcd/overflow take a new value
module score_bcd_sequencer #(
  parameter int BIN_W     = 14,
  parameter int MAX_SCORE = 9999
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  input  logic             update,
  input  logic [BIN_W-1:0] bin_score,
  output logic [15:0]      bcd,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam logic [BIN_W-1:0] MAX_BIN  = BIN_W'(MAX_SCORE);
  localparam logic [3:0]       LAST_CNT = 4'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] op;
  logic [15:0]      acc;
  logic [3:0]       cnt;
  logic             sat;
  logic             pend;
  logic [BIN_W-1:0] pend_val;

  // Pending request as it will be after this edge. A request that arrives
  // in the LOAD cycle is seen here, so it chains straight into CONV.
  logic             pend_nxt;
  logic [BIN_W-1:0] pend_val_nxt;

  always_comb begin
    pend_nxt     = pend;
    pend_val_nxt = pend_val;
    if (update && state != IDLE) begin
      pend_nxt     = 1'b1;
      pend_val_nxt = bin_score;
    end
  end

  // State register
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (update) state_nxt = CONV;
      CONV:    if (cnt == LAST_CNT) state_nxt = LOAD;
      LOAD:    state_nxt = pend_nxt ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  logic             cap, do_shift, do_load;
  logic [BIN_W-1:0] cap_val;

  always_comb begin
    cap      = (state == IDLE && update) || (state == LOAD && pend_nxt);
    cap_val  = (state == IDLE) ? bin_score : pend_val_nxt;
    do_shift = (state == CONV);
    do_load  = (state == LOAD);
  end

  logic             cap_sat;
  logic [BIN_W-1:0] cap_op;
  assign cap_sat = cap_val > MAX_BIN;
  assign cap_op  = cap_sat ? MAX_BIN : cap_val;

  // Add 3 to every nibble >= 5. Each nibble is handled on its own, with
  // no carry into the next one. After the shift every digit stays <= 9.
  logic [15:0] adj;
  always_comb begin
    adj = acc;
    for (int i = 0; i < 4; i++)
      if (acc[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
  end

  // Conversion datapath
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      op  <= '0;
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (cap) begin
      op  <= cap_op;
      sat <= cap_sat;
      acc <= '0;
      cnt <= '0;
    end else if (do_shift) begin
      {acc, op} <= {adj, op} << 1;
      cnt       <= cnt + 4'd1;
    end
  end

  // Pending request: only the newest value is kept
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      pend     <= 1'b0;
      pend_val <= '0;
    end else begin
      pend     <= (do_load && pend_nxt) ? 1'b0 : pend_nxt;
      pend_val <= pend_val_nxt;
    end
  end

  // Display holding register and status
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      bcd      <= 16'h0000;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (do_load) begin
        bcd      <= acc;
        overflow <= sat;
      end
      done <= do_load;
      busy <= (state_nxt != IDLE);
    end
  end

endmodule
